spinet_arbiter: RTL and testbench

Ring-access arbiter for the SPI node ring network. Grants exclusive transmit access to one of N ring nodes at a time using rotating (round-robin) priority, so injected words never collide on the shared ring. It sits beside the ring, taking per-node requests from the node SPI front ends and returning a one-hot grant plus the winner's address. An optional hold timeout revokes grants from nodes that stall.

---
 rtl/spinet_pkg.sv | 14 +
 rtl/spinet_rr_pick.sv | 40 ++++
 rtl/spinet_arbiter.sv | 118 +++++++++++
 tb/tb_spinet_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinet_pkg.sv
// Shared definitions for the SPI node ring: arbiter state encoding and
// the default ring size used by the ring, node and arbiter blocks.
package spinet_pkg;

    localparam int unsigned SPINET_N     = 8;
    localparam int unsigned SPINET_ABITS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/spinet_rr_pick.sv
// Rotating-priority finder: returns the first set request at or after ptr,
// wrapping modulo N. Indices >= N do not exist, so they are never picked.
module spinet_rr_pick import spinet_pkg::*; #(
    parameter int unsigned N     = SPINET_N,
    parameter int unsigned ABITS = SPINET_ABITS
) (
    input  logic [N-1:0]     req,
    input  logic [ABITS-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [ABITS-1:0] pick_id,
    output logic             any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned base;
    int unsigned idx;

    // Walk the N candidates in priority order and keep the first hit.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        // An out-of-range ptr cannot occur in normal use; treat it as 0.
        base    = (32'(ptr) < N) ? 32'(ptr) : 32'd0;
        idx     = 32'd0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx[IW-1:0]]) begin
                any                = 1'b1;
                pick[idx[IW-1:0]]  = 1'b1;
                pick_id            = ABITS'(idx);
            end
        end
    end

endmodule

// File: rtl/spinet_arbiter.sv
// Ring-access arbiter: round-robin grant of the shared ring to one node at a
// time, with a one-cycle dead period after each grant.
// Optional hold timeout: define SPINET_ARB_TIMEOUT_EN to revoke grants held
// for MAXHOLD cycles and pulse timeout.
module spinet_arbiter import spinet_pkg::*; #(
    parameter int unsigned N       = SPINET_N,
    parameter int unsigned ABITS   = SPINET_ABITS,
    parameter int unsigned MAXHOLD = 16,
    parameter int unsigned HBITS   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [ABITS-1:0] gnt_id,
    output logic             timeout,
    output logic             busy
);

    localparam int unsigned IW = $clog2(N);

    // Elaboration-time parameter sanity checks.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("spinet_arbiter: N must be in 2..16");
    end
    if ((1 << ABITS) < N || ABITS < IW) begin : g_bad_abits
        $error("spinet_arbiter: ABITS too narrow for N");
    end
    if (MAXHOLD < 2) begin : g_bad_maxhold
        $error("spinet_arbiter: MAXHOLD must be >= 2");
    end
    if ((1 << HBITS) <= MAXHOLD) begin : g_bad_hbits
        $error("spinet_arbiter: HBITS too narrow for MAXHOLD");
    end

    arb_state_t       state;
    logic [ABITS-1:0] ptr;
    logic [N-1:0]     pick;
    logic [ABITS-1:0] pick_id;
    logic             any;
    logic             normal_rel;
    logic [ABITS-1:0] next_ptr;
`ifdef SPINET_ARB_TIMEOUT_EN
    logic [HBITS-1:0] hold_cnt;
`endif

    spinet_rr_pick #(
        .N     (N),
        .ABITS (ABITS)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

    // Only the granted node's done/req are looked at; stray done bits vanish here.
    assign normal_rel = done[gnt_id[IW-1:0]] | ~req[gnt_id[IW-1:0]];
    // The node just served drops to lowest priority.
    assign next_ptr   = (32'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;

    assign gnt_valid  = |gnt;
    assign busy       = (state != IDLE);

    // Arbitration FSM with registered grant, winner id and timeout pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
`ifdef SPINET_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt      <= pick;
                        gnt_id   <= pick_id;
`ifdef SPINET_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (normal_rel) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= RELEASE;
`ifdef SPINET_ARB_TIMEOUT_EN
                    end else if (hold_cnt == HBITS'(MAXHOLD - 1)) begin
                        gnt     <= '0;
                        ptr     <= next_ptr;
                        timeout <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spinet_arbiter.sv
// Self-checking bench for spinet_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural reference model.
module tb_spinet_arbiter;

    localparam int NA      = 8;
    localparam int MAXHOLD = 16;
`ifdef SPINET_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   req_a = '0;
    logic [7:0]   done_a = '0;
    logic [7:0]   gnt_a;
    logic         gnt_valid_a;
    logic [2:0]   gnt_id_a;
    logic         timeout_a;
    logic         busy_a;

    logic [5:0]   req_b = '0;
    logic [5:0]   done_b = '0;
    logic [5:0]   gnt_b;
    logic         gnt_valid_b;
    logic [2:0]   gnt_id_b;
    logic         timeout_b;
    logic         busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spinet_arbiter #(.N(8), .ABITS(3), .MAXHOLD(MAXHOLD), .HBITS(5)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req_a),
        .done      (done_a),
        .gnt       (gnt_a),
        .gnt_valid (gnt_valid_a),
        .gnt_id    (gnt_id_a),
        .timeout   (timeout_a),
        .busy      (busy_a)
    );

    spinet_arbiter #(.N(6), .ABITS(3), .MAXHOLD(MAXHOLD), .HBITS(5)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .done      (done_b),
        .gnt       (gnt_b),
        .gnt_valid (gnt_valid_b),
        .gnt_id    (gnt_id_b),
        .timeout   (timeout_b),
        .busy      (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 holding, 2 dead cycle.
    int m_phase, m_ptr, m_id, m_age;
    bit m_to;

    function automatic void model_reset();
        m_phase = 0; m_ptr = 0; m_id = 0; m_age = 0; m_to = 1'b0;
    endfunction

    // Advance the model across one rising edge given the inputs before it.
    function automatic void model_step(input logic [7:0] r, input logic [7:0] d);
        bit found;
        m_to = 1'b0;
        if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 0; k < NA; k++) begin
                int c;
                c = (m_ptr + k) % NA;
                if (!found && r[c]) begin
                    found = 1'b1;
                    m_id = c;
                end
            end
            if (found) begin
                m_phase = 1;
                m_age = 0;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (d[m_id] || !r[m_id]) begin
                m_phase = 2;
                m_ptr = (m_id + 1) % NA;
            end else if (TO_EN && m_age == MAXHOLD) begin
                m_phase = 2;
                m_ptr = (m_id + 1) % NA;
                m_to = 1'b1;
            end
        end else begin
            m_phase = 0;
        end
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] g;
        g = '0;
        if (m_phase == 1) g[m_id] = 1'b1;
        return g;
    endfunction

    task automatic cycle();
        if (!rst) model_reset();
        else model_step(req_a, done_a);
        @(posedge clk);
        #1;
        check("gnt", gnt_a, exp_gnt());
        check("gnt_valid", gnt_valid_a, m_phase == 1);
        check("gnt_id", gnt_id_a, m_id);
        check("timeout", timeout_a, m_to);
        check("busy", busy_a, m_phase != 0);
    endtask

    task automatic go_idle();
        req_a = '0;
        done_a = '0;
        repeat (3) cycle();
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        model_reset();

        // Reset held with every node requesting.
        req_a = 8'hFF;
        done_a = 8'hFF;
        #2;
        check("rst_gnt0", gnt_a, 8'h00);
        check("rst_id0", gnt_id_a, 0);
        check("rst_to0", timeout_a, 0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        check("rst_first_grant", gnt_a, 8'h01);

        // Round robin with done every HOLD cycle: 3-cycle spacing.
        for (int i = 1; i <= 8; i++) begin
            repeat (3) cycle();
            check("rr_valid", gnt_valid_a, 1);
            check("rr_order", gnt_id_a, i % 8);
        end

        // Stray done ignored; own done and req drop both release.
        go_idle();
        req_a = 8'h04;
        cycle();
        check("stray_grant", gnt_a, 8'h04);
        done_a = 8'h10;
        cycle();
        check("stray_ignored", gnt_a, 8'h04);
        done_a = 8'h14;
        cycle();
        check("stray_release", gnt_a, 8'h00);
        done_a = 8'h00;
        repeat (2) cycle();
        check("regrant2", gnt_a, 8'h04);
        req_a = 8'h00;
        cycle();
        check("reqdrop_release", gnt_a, 8'h00);

        go_idle();
        req_a = 8'h08;
        cycle();
        check("to_grant", gnt_a, 8'h08);
`ifdef SPINET_ARB_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            n++;
            if (!gnt_valid_a) seen = 1'b1;
        end
        check("to_len", n, MAXHOLD);
        check("to_pulse", timeout_a, 1);
        req_a = 8'hFF;
        cycle();
        check("to_pulse_once", timeout_a, 0);
        cycle();
        check("to_ptr", gnt_id_a, 4);
        repeat (MAXHOLD - 1) cycle();
        done_a = 8'h10;
        cycle();
        check("to_done_wins_gnt", gnt_valid_a, 0);
        check("to_done_wins_pulse", timeout_a, 0);
        done_a = 8'h00;
`else
        n = 0;
        seen = 1'b0;
        repeat (MAXHOLD + 4) cycle();
        check("noto_hold", gnt_a, 8'h08);
        check("noto_pulse", timeout_a, 0);
`endif

        // Random traffic against the model, several intensity phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, (ph == 0) ? 1 : 7) == 0) req_a = 8'($urandom);
                done_a = ($urandom_range(0, (ph < 2) ? 3 : 40) == 0) ? 8'($urandom) : 8'h00;
                cycle();
            end
        end

        // Asynchronous reset in the middle of a grant.
        go_idle();
        req_a = 8'h20;
        cycle();
        cycle();
        check("arst_pre", gnt_a, 8'h20);
        #3;
        rst = 1'b0;
        #1;
        check("arst_gnt", gnt_a, 8'h00);
        check("arst_valid", gnt_valid_a, 0);
        check("arst_busy", busy_a, 0);
        cycle();
        rst = 1'b1;
        req_a = 8'hFF;
        cycle();
        check("arst_restart", gnt_a, 8'h01);

        // N=6 instance: serve node 5, pointer wraps to 0.
        req_b = 6'b100000;
        @(posedge clk); #1;
        check("n6_grant5", gnt_b, 6'b100000);
        check("n6_id5", gnt_id_b, 5);
        done_b = 6'b100000;
        @(posedge clk); #1;
        check("n6_rel5", gnt_b, 6'b000000);
        done_b = 6'b000000;
        req_b = 6'b000011;
        @(posedge clk); #1;
        check("n6_dead", gnt_b, 6'b000000);
        @(posedge clk); #1;
        check("n6_wrap0", gnt_b, 6'b000001);
        done_b = 6'b000001;
        @(posedge clk); #1;
        done_b = 6'b000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("n6_next1", gnt_b, 6'b000010);
        check("n6_id1", gnt_id_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
